// File: rtl/ser_10b_pkg.sv
// Shared constants and helpers for the 10-bit transmit serializer.
package ser_10b_pkg;

  localparam int WORD_W = 10;
  localparam int CNT_W  = 4;

  localparam logic [WORD_W-1:0] K28_5_NEG = 10'b0011111010;
  localparam logic [WORD_W-1:0] K28_5_POS = 10'b1100000101;

  localparam logic [CNT_W-1:0] CNT_FIRST = 4'd0;
  localparam logic [CNT_W-1:0] CNT_LAST  = 4'd9;

  function automatic logic [CNT_W-1:0] popcount10(input logic [WORD_W-1:0] w);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < WORD_W; i++) begin
      n = n + {{(CNT_W-1){1'b0}}, w[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/ser_rd_track.sv
// Running-disparity next-state and violation decode for one loaded 10-bit word.
module ser_rd_track
  import ser_10b_pkg::*;
(
  input  logic              load_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              rd_i,
  output logic              rd_o,
  output logic              viol_o
);

  logic [CNT_W-1:0] ones;

  always_comb begin
    ones   = popcount10(word_i);
    rd_o   = rd_i;
    viol_o = 1'b0;
    if (load_i) begin
      if (ones == 4'd6) begin
        rd_o   = 1'b1;
        viol_o = rd_i;
      end else if (ones == 4'd4) begin
        rd_o   = 1'b0;
        viol_o = ~rd_i;
      end else if (ones != 4'd5) begin
        // unbalanced word: disparity cannot be trusted, keep the old RD
        viol_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ser_10b.sv
// 10-bit parallel-to-serial stage with K28.5 idle insertion and running-disparity tracking.
// Define SER_RD_CHECK_EN to add the sticky rd_err disparity-violation output.
module ser_10b
  import ser_10b_pkg::*;
#(
  parameter logic [WORD_W-1:0] IDLE_NEG = K28_5_NEG,
  parameter logic [WORD_W-1:0] IDLE_POS = K28_5_POS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              tx_bit,
  output logic              tx_sow,
  output logic              tx_idle,
  output logic              underrun,
  output logic              tx_rd
`ifdef SER_RD_CHECK_EN
  ,
  output logic              rd_err
`endif
);

  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_q, rd_d;
  logic              idle_q, idle_d;
  logic              last_data_q, last_data_d;
  logic              underrun_q, underrun_d;
  logic              load;
  logic [WORD_W-1:0] load_word;
  logic              rd_viol;

  assign load = (cnt_q == CNT_LAST);

  // An idle word is picked to balance the current line disparity.
  assign load_word = in_valid ? in_data : (rd_q ? IDLE_POS : IDLE_NEG);

  ser_rd_track u_rd_track (
    .load_i (load),
    .word_i (load_word),
    .rd_i   (rd_q),
    .rd_o   (rd_d),
    .viol_o (rd_viol)
  );

  always_comb begin
    shreg_d     = {shreg_q[WORD_W-2:0], 1'b0};
    cnt_d       = cnt_q + 4'd1;
    idle_d      = idle_q;
    last_data_d = last_data_q;
    underrun_d  = 1'b0;
    if (load) begin
      shreg_d     = load_word;
      cnt_d       = CNT_FIRST;
      idle_d      = ~in_valid;
      last_data_d = in_valid;
      underrun_d  = ~in_valid & last_data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q     <= '0;
      cnt_q       <= CNT_LAST;
      rd_q        <= 1'b0;
      idle_q      <= 1'b0;
      last_data_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      idle_q      <= idle_d;
      last_data_q <= last_data_d;
      underrun_q  <= underrun_d;
    end
  end

`ifdef SER_RD_CHECK_EN
  logic rd_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_err_q <= 1'b0;
    end else begin
      rd_err_q <= rd_err_q | (rd_viol & in_valid);
    end
  end

  assign rd_err = rd_err_q;
`else
  logic rd_viol_unused;
  assign rd_viol_unused = rd_viol;
`endif

  assign in_ready = load;
  assign tx_bit   = shreg_q[WORD_W-1];
  assign tx_sow   = (cnt_q == CNT_FIRST) & ~rst;
  assign tx_idle  = idle_q;
  assign underrun = underrun_q;
  assign tx_rd    = rd_q;

endmodule
